// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle main controller for the MIPS core.
//
// Moore FSM that sequences fetch, decode, execute, memory and write-back for
// the supported instruction classes. Each instruction issues exactly one
// pc_we pulse, in its final state.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   opcode, funct     IR[31:26], IR[5:0]; sampled only in DECODE
//   zero              ALU result == 0; steers npc_sel in BRANCH
//   state             current FSM state (debug)
//   ir_we, pc_we      IR load, PC load from NPC
//   npc_sel           0 ADD4, 1 OFFSET, 2 JUMP_S, 3 JUMP_L
//   ext_op            0 zero-ext, 1 sign-ext, 2 lui
//   alu_b_sel, alu_op ALU B source (0 rt, 1 imm); 0 add, 1 sub, 2 or
//   grf_we            register-file write
//   grf_a3_sel        0 rd, 1 rt, 2 $31
//   grf_wd_sel        0 ALU, 1 DM, 2 PC_4
//   dm_we             data-memory write
//   instr_cnt         instructions retired since reset (wraps)
// ---------------------------------------------------------------------------
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [2:0]       state,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic [1:0]       ext_op,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             grf_we,
    output logic [1:0]       grf_a3_sel,
    output logic [1:0]       grf_wd_sel,
    output logic             dm_we,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_NOP    = 3'd7
    } state_t;

    // R_ALU is split into addu/subu because the ALU op differs.
    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW,
        C_BEQ, C_J, C_JAL, C_JR, C_OTHER
    } cls_t;

    state_t cur_state, nxt_state;
    cls_t   cls_q, cls_dec;

    // Raw strobes before the reset gate.
    logic ir_we_raw, pc_we_raw, grf_we_raw, dm_we_raw;

    // ------------------------------------------------------------------
    // Instruction decode (only consumed in DECODE)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cls_dec = C_OTHER;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: cls_dec = C_ADDU;
                    6'b100011: cls_dec = C_SUBU;
                    6'b001000: cls_dec = C_JR;
                    default:   cls_dec = C_OTHER;
                endcase
            end
            6'b001101: cls_dec = C_ORI;
            6'b001111: cls_dec = C_LUI;
            6'b100011: cls_dec = C_LW;
            6'b101011: cls_dec = C_SW;
            6'b000100: cls_dec = C_BEQ;
            6'b000010: cls_dec = C_J;
            6'b000011: cls_dec = C_JAL;
            default:   cls_dec = C_OTHER;
        endcase
    end

    // ------------------------------------------------------------------
    // State and class registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (rst) begin
            cur_state <= S_FETCH;
            cls_q     <= C_OTHER;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) begin
                cls_q <= cls_dec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH: nxt_state = S_DECODE;
            S_DECODE: begin
                // The class register is not loaded yet; steer from the
                // live decode.
                case (cls_dec)
                    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW: nxt_state = S_EXEC;
                    C_BEQ:                                    nxt_state = S_BRANCH;
                    C_J, C_JAL, C_JR:                         nxt_state = S_JUMP;
                    default:                                  nxt_state = S_NOP;
                endcase
            end
            S_EXEC: begin
                if (cls_q == C_LW || cls_q == C_SW) nxt_state = S_MEM;
                else                                nxt_state = S_WB;
            end
            S_MEM: begin
                if (cls_q == C_LW) nxt_state = S_WB;
                else               nxt_state = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs (npc_sel in BRANCH is the only input-dependent one)
    // ------------------------------------------------------------------
    always_comb begin
        ir_we_raw  = 1'b0;
        pc_we_raw  = 1'b0;
        grf_we_raw = 1'b0;
        dm_we_raw  = 1'b0;
        npc_sel    = 2'd0;
        ext_op     = 2'd0;
        alu_b_sel  = 1'b0;
        alu_op     = 2'd0;
        grf_a3_sel = 2'd0;
        grf_wd_sel = 2'd0;

        // ALU controls are held across EXEC/MEM/WB so the datapath result
        // stays stable until it is written. LUI relies on the datapath
        // forcing ALU A to $0.
        if (cur_state == S_EXEC || cur_state == S_MEM || cur_state == S_WB) begin
            case (cls_q)
                C_SUBU: alu_op = 2'd1;
                C_ORI: begin
                    alu_op    = 2'd2;
                    alu_b_sel = 1'b1;
                end
                C_LUI: begin
                    alu_op    = 2'd2;
                    alu_b_sel = 1'b1;
                    ext_op    = 2'd2;
                end
                C_LW, C_SW: begin
                    alu_b_sel = 1'b1;
                    ext_op    = 2'd1;
                end
                default: ;
            endcase
        end

        case (cur_state)
            S_FETCH: ir_we_raw = 1'b1;
            S_MEM: begin
                if (cls_q == C_SW) begin
                    dm_we_raw = 1'b1;
                    pc_we_raw = 1'b1;
                end
            end
            S_WB: begin
                grf_we_raw = 1'b1;
                pc_we_raw  = 1'b1;
                if (cls_q == C_LW) begin
                    grf_a3_sel = 2'd1;
                    grf_wd_sel = 2'd1;
                end else if (cls_q == C_ORI || cls_q == C_LUI) begin
                    grf_a3_sel = 2'd1;
                end
            end
            S_BRANCH: begin
                alu_op    = 2'd1;
                ext_op    = 2'd1;
                pc_we_raw = 1'b1;
                npc_sel   = {1'b0, zero};
            end
            S_JUMP: begin
                pc_we_raw = 1'b1;
                case (cls_q)
                    C_JR:  npc_sel = 2'd3;
                    C_JAL: begin
                        npc_sel    = 2'd2;
                        grf_we_raw = 1'b1;
                        grf_a3_sel = 2'd2;
                        grf_wd_sel = 2'd2;
                    end
                    default: npc_sel = 2'd2;
                endcase
            end
            S_NOP: pc_we_raw = 1'b1;
            default: ;
        endcase
    end

    // Reset aborts the instruction immediately: no write commits on an
    // edge where rst is high.
    assign ir_we  = ir_we_raw  & ~rst;
    assign pc_we  = pc_we_raw  & ~rst;
    assign grf_we = grf_we_raw & ~rst;
    assign dm_we  = dm_we_raw  & ~rst;
    assign state  = cur_state;

    // ------------------------------------------------------------------
    // Retired-instruction counter: one pc_we per instruction
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt <= '0;
        end else if (pc_we) begin
            instr_cnt <= instr_cnt + 1'b1;
        end
    end

endmodule
